// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the single-clock first-word-fall-through FIFO.
package async_fifo_pkg;

  localparam int DEF_DSIZE = 32;
  localparam int DEF_ASIZE = 4;

  function automatic int depth(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port storage: synchronous write, asynchronous (show-ahead) read.
module fifo_ram
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [depth(ASIZE)];

  // NOTE: storage has no reset; the pointers alone define which words are valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/async_fifo_single_clock.sv
// Single-clock FWFT FIFO: wrap-bit pointers, occupancy count and status flags
// decoded from registered pointers around a fifo_ram instance.
module async_fifo_single_clock
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty
);

  localparam logic [ASIZE:0] PTR_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE:0] CNT_AFULL = (ASIZE+1)'(depth(ASIZE) - 1);

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] count;
  logic           wr_en, rd_en;

  assign wr_en = winc & ~wfull;
  assign rd_en = rinc & ~rempty;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + PTR_ONE;
    if (rd_en) rptr_d = rptr_q + PTR_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Flags depend only on registered pointers, never on winc/rinc.
  assign count   = wptr_q - rptr_q;
  assign rempty  = (wptr_q == rptr_q);
  assign wfull   = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                   (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
  assign awfull  = (count == CNT_AFULL);
  assign arempty = (count == PTR_ONE);

  fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wptr_q[ASIZE-1:0]),
    .wdata_i(wdata),
    .raddr_i(rptr_q[ASIZE-1:0]),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_async_fifo_single_clock.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_async_fifo_single_clock;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        winc, rinc;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wfull, awfull, rempty, arempty;

  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  async_fifo_single_clock #(.DSIZE(32), .ASIZE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .wdata  (wdata),
    .wfull  (wfull),
    .awfull (awfull),
    .rinc   (rinc),
    .rdata  (rdata),
    .rempty (rempty),
    .arempty(arempty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the occupancy of the model queue implies.
  task automatic check_all(input string tag);
    check({tag, "_rempty"},  32'(rempty),  32'(mq.size() == 0));
    check({tag, "_wfull"},   32'(wfull),   32'(mq.size() == DEPTH));
    check({tag, "_awfull"},  32'(awfull),  32'(mq.size() == DEPTH - 1));
    check({tag, "_arempty"}, 32'(arempty), 32'(mq.size() == 1));
    if (mq.size() != 0) check({tag, "_rdata"}, rdata, mq[0]);
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, check.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r, input string tag);
    bit acc_w, acc_r;
    winc  = w;
    wdata = d;
    rinc  = r;
    acc_w = w && (mq.size() < DEPTH);
    acc_r = r && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (acc_r) void'(mq.pop_front());
    if (acc_w) mq.push_back(d);
    winc = 1'b0;
    rinc = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset idle
    repeat (10) @(posedge clk);
    #1;
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_awfull", 32'(awfull), 32'd0);
    check("rst_arempty", 32'(arempty), 32'd0);

    // Single word
    cycle(1'b1, 32'hA, 1'b0, "single_wr");
    check("single_rdata", rdata, 32'hA);
    check("single_arempty", 32'(arempty), 32'd1);
    check("single_rempty0", 32'(rempty), 32'd0);
    cycle(1'b0, '0, 1'b1, "single_rd");
    check("single_rempty1", 32'(rempty), 32'd1);
    check("single_arempty0", 32'(arempty), 32'd0);

    // Burst
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 1'b0, "burst_wr");
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, "burst_idle");
    for (int i = 0; i < 10; i++) begin
      check("burst_seq", rdata, 32'(i));
      cycle(1'b0, '0, 1'b1, "burst_rd");
    end
    check("burst_empty", 32'(rempty), 32'd1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'(i), 1'b0, "fill_wr");
      if (i == DEPTH - 2) check("fill_awfull15", 32'(awfull), 32'd1);
    end
    check("fill_wfull16", 32'(wfull), 32'd1);
    check("fill_awfull16", 32'(awfull), 32'd0);
    cycle(1'b1, 32'd99, 1'b0, "fill_drop");
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_drain", rdata, 32'(i));
      cycle(1'b0, '0, 1'b1, "fill_rd");
    end
    check("fill_empty", 32'(rempty), 32'd1);

    // Wrap with simultaneous traffic at constant occupancy
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'(100 + i), 1'b0, "wrap_fill");
    for (int j = 0; j < 40; j++) begin
      check("wrap_order", rdata, 32'(100 + j));
      cycle(1'b1, 32'(108 + j), 1'b1, "wrap_rw");
      check("wrap_count", 32'(mq.size()), 32'd8);
      check("wrap_nofull", 32'(wfull), 32'd0);
      check("wrap_noempty", 32'(rempty), 32'd0);
    end
    for (int j = 0; j < 8; j++) begin
      check("wrap_drain", rdata, 32'(140 + j));
      cycle(1'b0, '0, 1'b1, "wrap_rd");
    end

    // Reset mid-operation, pulsed between edges
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'(200 + i), 1'b0, "mid_wr");
    rst = 1'b1;
    #2;
    mq.delete();
    check("mid_rempty", 32'(rempty), 32'd1);
    check("mid_arempty", 32'(arempty), 32'd0);
    rst = 1'b0;
    cycle(1'b1, 32'h55, 1'b0, "mid_newwr");
    check("mid_newdata", rdata, 32'h55);
    cycle(1'b0, '0, 1'b1, "mid_newrd");
    check("mid_empty", 32'(rempty), 32'd1);

    // Random traffic, biased so the FIFO visits both ends
    for (int n = 0; n < 600; n++) begin
      int bias;
      bias = (n < 200) ? 70 : (n < 400) ? 30 : 50;
      cycle(1'($urandom_range(99) < bias), $urandom, 1'($urandom_range(99) >= bias), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
